// File: rtl/reset_sequencer_if.sv
// Lock, software-request and staged-reset signals between the PLL-side
// sequencer and the reset domains it controls.
interface reset_sequencer_if #(
    parameter int NUM_OUTPUTS = 3,
    parameter int LOSS_WIDTH  = 8
);
    logic                   locked_async;
    logic                   sw_reset_req;
    logic [NUM_OUTPUTS-1:0] reset_out;
    logic                   ready;
    logic [LOSS_WIDTH-1:0]  loss_count;

    // The sequencer consumes lock and request and drives the resets.
    modport master (
        input  locked_async,
        input  sw_reset_req,
        output reset_out,
        output ready,
        output loss_count
    );

    // The surrounding logic supplies lock and request and observes the resets.
    modport slave (
        output locked_async,
        output sw_reset_req,
        input  reset_out,
        input  ready,
        input  loss_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset sequencer in the pll_clk domain: synchronises the PLL lock,
// qualifies it for LOCK_CYCLES, then releases NUM_OUTPUTS reset domains
// STAGE_DELAY cycles apart. Lock loss or a software request re-asserts all
// resets; lock losses after first release are counted (saturating).
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_CYCLES    = 16,
    parameter int NUM_OUTPUTS    = 3,
    parameter int STAGE_DELAY    = 8,
    parameter int SW_HOLD_CYCLES = 4,
    parameter int LOSS_WIDTH     = 8
) (
    input  logic            clk,
    input  logic            reset,
    reset_sequencer_if.master bus
);

    localparam int QUAL_W  = (LOCK_CYCLES > 1)    ? $clog2(LOCK_CYCLES)    : 1;
    localparam int STAGE_W = (STAGE_DELAY > 1)    ? $clog2(STAGE_DELAY)    : 1;
    localparam int HOLD_W  = (SW_HOLD_CYCLES > 1) ? $clog2(SW_HOLD_CYCLES) : 1;

    localparam logic [QUAL_W-1:0]  QUAL_LAST  = QUAL_W'(LOCK_CYCLES - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SW_HOLD_CYCLES - 1);

    localparam logic [NUM_OUTPUTS-1:0] ALL_ON    = {NUM_OUTPUTS{1'b1}};
    localparam logic [NUM_OUTPUTS-1:0] FIRST_OFF = ALL_ON << 1;
    localparam logic [NUM_OUTPUTS-1:0] LAST_ON   = NUM_OUTPUTS'(1) << (NUM_OUTPUTS - 1);
    localparam bit                     SINGLE    = (NUM_OUTPUTS == 1);

    localparam logic [1:0] ST_QUALIFY = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_SW_HOLD = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [1:0]             state;
    logic [QUAL_W-1:0]      qual_cnt;
    logic [STAGE_W-1:0]     stage_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [NUM_OUTPUTS-1:0] reset_out_q;
    logic                   ready_q;
    logic [LOSS_WIDTH-1:0]  loss_q;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Bring the raw PLL lock into the clk domain through a shift chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked_async};
        end
    end

    // Sequencer: qualify lock, release resets one stage at a time, and fall
    // back to full reset on lock loss (counted) or a software request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_QUALIFY;
            qual_cnt    <= '0;
            stage_cnt   <= '0;
            hold_cnt    <= '0;
            reset_out_q <= ALL_ON;
            ready_q     <= 1'b0;
            loss_q      <= '0;
        end else begin
            case (state)
                ST_QUALIFY: begin
                    if (!locked_s) begin
                        qual_cnt <= '0;
                    end else if (qual_cnt == QUAL_LAST) begin
                        qual_cnt    <= '0;
                        stage_cnt   <= '0;
                        reset_out_q <= FIRST_OFF;
                        if (SINGLE) begin
                            ready_q <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            state   <= ST_RELEASE;
                        end
                    end else begin
                        qual_cnt <= qual_cnt + 1'b1;
                    end
                end

                ST_RELEASE, ST_RUN, ST_SW_HOLD: begin
                    if (!locked_s) begin
                        // Lock loss beats a coincident software request.
                        reset_out_q <= ALL_ON;
                        ready_q     <= 1'b0;
                        qual_cnt    <= '0;
                        state       <= ST_QUALIFY;
                        if (loss_q != {LOSS_WIDTH{1'b1}}) begin
                            loss_q <= loss_q + 1'b1;
                        end
                    end else if (state == ST_SW_HOLD) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt    <= '0;
                            stage_cnt   <= '0;
                            reset_out_q <= FIRST_OFF;
                            if (SINGLE) begin
                                ready_q <= 1'b1;
                                state   <= ST_RUN;
                            end else begin
                                state   <= ST_RELEASE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (bus.sw_reset_req) begin
                        reset_out_q <= ALL_ON;
                        ready_q     <= 1'b0;
                        hold_cnt    <= '0;
                        state       <= ST_SW_HOLD;
                    end else if (state == ST_RELEASE) begin
                        if (stage_cnt == STAGE_LAST) begin
                            stage_cnt   <= '0;
                            reset_out_q <= reset_out_q << 1;
                            if (reset_out_q == LAST_ON) begin
                                ready_q <= 1'b1;
                                state   <= ST_RUN;
                            end
                        end else begin
                            stage_cnt <= stage_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_QUALIFY;
                end
            endcase
        end
    end

    assign bus.reset_out  = reset_out_q;
    assign bus.ready      = ready_q;
    assign bus.loss_count = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: table-driven default sequence,
// hand-written corner cases, and a randomized run against a timeline model.
module tb_reset_sequencer;

    localparam int SYNC  = 2;
    localparam int LOCKC = 16;
    localparam int NOUT  = 3;
    localparam int SDLY  = 8;
    localparam int HOLDC = 4;

    logic clk;
    logic reset;
    logic locked;
    logic sw;

    int vectors;
    int miscompares;

    reset_sequencer_if #(.NUM_OUTPUTS(3), .LOSS_WIDTH(8)) bus0 ();
    reset_sequencer_if #(.NUM_OUTPUTS(1), .LOSS_WIDTH(8)) bus1 ();
    reset_sequencer_if #(.NUM_OUTPUTS(3), .LOSS_WIDTH(2)) bus2 ();

    assign bus0.locked_async = locked;
    assign bus0.sw_reset_req = sw;
    assign bus1.locked_async = locked;
    assign bus1.sw_reset_req = sw;
    assign bus2.locked_async = locked;
    assign bus2.sw_reset_req = sw;

    reset_sequencer dut0 (.clk(clk), .reset(reset), .bus(bus0));

    reset_sequencer #(
        .SYNC_STAGES(3), .LOCK_CYCLES(1), .NUM_OUTPUTS(1)
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    reset_sequencer #(
        .LOSS_WIDTH(2)
    ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst_first;
        logic       lock;
        logic       sw;
        int         edges;
        logic [2:0] exp_out;
        logic       exp_ready;
        logic [7:0] exp_loss;
    } vec_t;

    vec_t vecs[24];

    // Timeline reference model: lock history queue plus "edges since the
    // first output was released", from which each output's level follows.
    bit lq[$];
    int m_mode;      // 0 qualifying, 1 released, 2 software hold
    int m_qual;
    int m_elapsed;
    int m_hold;
    int m_loss;

    function automatic void model_reset();
        lq.delete();
        for (int i = 0; i < SYNC; i++) lq.push_back(1'b0);
        m_mode = 0; m_qual = 0; m_elapsed = 0; m_hold = 0; m_loss = 0;
    endfunction

    function automatic void model_step(input bit lock_in, input bit sw_in);
        bit ls;
        ls = lq.pop_front();
        lq.push_back(lock_in);
        if (m_mode == 0) begin
            if (ls) begin
                m_qual++;
                if (m_qual == LOCKC) begin
                    m_mode = 1; m_elapsed = 0; m_qual = 0;
                end
            end else begin
                m_qual = 0;
            end
        end else if (!ls) begin
            m_mode = 0; m_qual = 0; m_loss++;
        end else if (m_mode == 1) begin
            if (sw_in) begin
                m_mode = 2; m_hold = 0;
            end else if (m_elapsed < 100000) begin
                m_elapsed++;
            end
        end else begin
            m_hold++;
            if (m_hold == HOLDC) begin
                m_mode = 1; m_elapsed = 0;
            end
        end
    endfunction

    function automatic logic [2:0] model_out();
        logic [2:0] r;
        for (int k = 0; k < NOUT; k++) r[k] = !(m_mode == 1 && m_elapsed >= SDLY * k);
        return r;
    endfunction

    function automatic logic model_ready();
        return (m_mode == 1 && m_elapsed >= SDLY * (NOUT - 1));
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_dut0(input string name, input logic [2:0] e_out, input logic e_rdy,
                              input logic [7:0] e_loss);
        vectors++;
        if ({bus0.reset_out, bus0.ready, bus0.loss_count} !== {e_out, e_rdy, e_loss}) begin
            miscompares++;
            $display("[TB] FAIL %s: got out=%b rdy=%b loss=%0d, expected out=%b rdy=%b loss=%0d",
                     name, bus0.reset_out, bus0.ready, bus0.loss_count, e_out, e_rdy, e_loss);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_reset();
        reset  = 1'b1;
        locked = 1'b0;
        sw     = 1'b0;
        tick(1);
        reset  = 1'b0;
        model_reset();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        locked = 1'b0;
        sw     = 1'b0;
        model_reset();

        // Default power-up, software reset and lock loss in RUN.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 17, 3'b111, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0,  1, 3'b110, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0,  7, 3'b110, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0,  1, 3'b100, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0,  7, 3'b100, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0,  1, 3'b000, 1'b1, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0,  5, 3'b000, 1'b1, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1,  1, 3'b111, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0,  3, 3'b111, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0,  1, 3'b110, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0,  7, 3'b110, 1'b0, 8'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b0,  1, 3'b100, 1'b0, 8'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0,  7, 3'b100, 1'b0, 8'd0};
        vecs[13] = '{1'b0, 1'b1, 1'b0,  1, 3'b000, 1'b1, 8'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b0,  2, 3'b000, 1'b1, 8'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b0,  1, 3'b111, 1'b0, 8'd1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 17, 3'b111, 1'b0, 8'd1};
        vecs[17] = '{1'b0, 1'b1, 1'b0,  1, 3'b110, 1'b0, 8'd1};
        vecs[18] = '{1'b0, 1'b1, 1'b0,  8, 3'b100, 1'b0, 8'd1};
        vecs[19] = '{1'b0, 1'b1, 1'b0,  8, 3'b000, 1'b1, 8'd1};
        // Glitchy lock: one low sample restarts qualification.
        vecs[20] = '{1'b1, 1'b1, 1'b0, 10, 3'b111, 1'b0, 8'd0};
        vecs[21] = '{1'b0, 1'b0, 1'b0,  1, 3'b111, 1'b0, 8'd0};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 17, 3'b111, 1'b0, 8'd0};
        vecs[23] = '{1'b0, 1'b1, 1'b0,  1, 3'b110, 1'b0, 8'd0};

        tick(2);
        check_dut0("reset_state", 3'b111, 1'b0, 8'd0);
        reset = 1'b0;

        // Single-output, 3-stage sync, 1-cycle qualify: release at edge 4.
        locked = 1'b1;
        tick(3);
        check("dut1_before_edge4", {31'd0, bus1.reset_out} << 1 | 32'(bus1.ready), 32'd2);
        tick(1);
        check("dut1_at_edge4", {30'd0, bus1.reset_out, bus1.ready}, 32'd1);
        check("dut1_loss", 32'(bus1.loss_count), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) pulse_reset();
            locked = vecs[i].lock;
            sw     = vecs[i].sw;
            tick(vecs[i].edges);
            check_dut0($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_ready, vecs[i].exp_loss);
        end
        sw = 1'b0;

        // Software request coincident with locked_s falling: lock loss wins.
        pulse_reset();
        locked = 1'b1;
        tick(40);
        check_dut0("prio_run", 3'b000, 1'b1, 8'd0);
        locked = 1'b0;
        tick(2);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        check_dut0("prio_loss", 3'b111, 1'b0, 8'd1);
        locked = 1'b1;
        tick(17);
        check_dut0("prio_requal", 3'b111, 1'b0, 8'd1);
        tick(1);
        check_dut0("prio_release", 3'b110, 1'b0, 8'd1);

        // Five lock losses: the 2-bit counter saturates at 3.
        pulse_reset();
        repeat (5) begin
            locked = 1'b1;
            tick(20);
            locked = 1'b0;
            tick(4);
        end
        check_dut0("loss_five", 3'b111, 1'b0, 8'd5);
        check("loss_saturate", 32'(bus2.loss_count), 32'd3);

        // Asynchronous reset between edges while in RELEASE.
        locked = 1'b1;
        tick(20);
        check_dut0("mid_release", 3'b110, 1'b0, 8'd5);
        #1 reset = 1'b1;
        #1;
        check_dut0("async_reset", 3'b111, 1'b0, 8'd0);
        check("async_reset_dut2", {28'd0, bus2.reset_out, bus2.ready}, 32'hE);
        #1 reset = 1'b0;
        tick(1);

        // Randomized lock/request traffic against the timeline model.
        pulse_reset();
        for (int i = 0; i < 4000; i++) begin
            if (locked) begin
                if ($urandom_range(199) == 0) locked = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                locked = 1'b1;
            end
            sw = ($urandom_range(49) == 0);
            @(posedge clk);
            model_step(locked, sw);
            #2;
            check_dut0($sformatf("rand%0d", i), model_out(), model_ready(), 8'(m_loss > 255 ? 255 : m_loss));
            check($sformatf("rand%0d_dut2", i), {28'd0, bus2.reset_out, bus2.ready},
                  {28'd0, model_out(), model_ready()});
            check($sformatf("rand%0d_loss2", i), 32'(bus2.loss_count), 32'(m_loss > 3 ? 3 : m_loss));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output PLL-lock reset counter in the top level.
- Synchronises an asynchronous PLL/oscillator lock, qualifies it for a programmable number of cycles, then releases NUM_OUTPUTS reset domains in staged order.
- Re-enters reset on lock loss or on a software reset request, and counts lock-loss events.
- Sits between the pll instance and the core and peripherals, in the pll_clk domain.

Parameters:
SYNC_STAGES, 2, flops in the lock synchroniser (legal >=2)
LOCK_CYCLES, 16, consecutive synchronised-lock cycles required before first release (legal >=1)
NUM_OUTPUTS, 3, number of staged reset outputs (legal >=1)
STAGE_DELAY, 8, cycles between successive output deassertions (legal >=1)
SW_HOLD_CYCLES, 4, cycles all outputs are held after a software request (legal >=1)
LOSS_WIDTH, 8, width of the saturating lock-loss counter

Ports:
clk  input  1  sequencer clock (pll_clk)
reset  input  1  asynchronous, active-high reset, e.g. from a button; forces all state to reset values immediately
locked_async  input  1  raw PLL lock, asynchronous to clk
sw_reset_req  input  1  single-cycle software reset request, synchronous to clk
reset_out  output  NUM_OUTPUTS  active-high domain resets; bit 0 is released first
ready  output  1  high when all reset_out bits are deasserted (state RUN)
loss_count  output  LOSS_WIDTH  saturating count of lock losses after first release

Behaviour:
- Reset values (asynchronous): synchroniser flops=0, state=QUALIFY, qual counter=0, stage counter=0, reset_out=all 1s, ready=0, loss_count=0.
- locked_s = last synchroniser stage. locked_async going high before edge e makes locked_s high after edge e+SYNC_STAGES-1.
- State QUALIFY:
  - All outputs are asserted.
  - qual_cnt increments on each edge where locked_s=1 and clears to 0 on any edge where locked_s=0.
  - On an edge where locked_s=1 and qual_cnt==LOCK_CYCLES-1: reset_out[0]<=0, stage counter<=0, go to RELEASE (or to RUN with ready<=1 if NUM_OUTPUTS==1).
  - Net latency with stable lock: reset_out[0] falls SYNC_STAGES+LOCK_CYCLES edges after locked_async rises (18 with defaults).
- State RELEASE:
  - The stage counter counts to STAGE_DELAY-1, then deasserts the next reset_out bit in ascending index order and clears.
  - reset_out[k] falls STAGE_DELAY*k edges after reset_out[0]. Once deasserted, a bit stays low until a return to reset.
  - On the edge the last bit falls: ready<=1, go to RUN.
- State RUN: outputs are static.
- Lock loss:
  - Condition: locked_s=0 in RELEASE or RUN.
  - Next edge: reset_out<=all 1s, ready<=0, qual_cnt<=0, go to QUALIFY.
  - loss_count increments, saturating at all 1s.
  - Lock loss during QUALIFY only clears qual_cnt and is not counted.
- Software request:
  - Condition: sw_reset_req=1 in RELEASE or RUN with locked_s=1.
  - Next edge: reset_out<=all 1s, ready<=0, hold counter<=0, go to SW_HOLD.
  - sw_reset_req is ignored in QUALIFY and SW_HOLD.
- State SW_HOLD:
  - All outputs stay asserted for SW_HOLD_CYCLES edges.
  - On the edge the hold counter reaches SW_HOLD_CYCLES-1: reset_out[0]<=0, go to RELEASE, skipping re-qualification.
  - If locked_s=0 at any edge in SW_HOLD, go to QUALIFY; this counts as a lock loss.
- Simultaneous lock loss and sw_reset_req: lock loss wins and loss_count increments.
- Asynchronous reset mid-sequence: everything returns to reset values at once; the sequence restarts from the synchroniser.
- reset_out and ready are direct register outputs; there is no combinational path from any input.
- Counter widths are $clog2 of their terminal value, minimum 1 bit. There is no wrap-around other than the defined clears.

Test Plan:
- Power-up, defaults: deassert reset, then raise locked_async at edge 0 and hold → reset_out[0] falls at edge 18, [1] at 26, [2] at 34; ready rises at 34; loss_count=0.
- Glitchy lock: locked_async high 10 cycles, low 1 cycle (spanning an edge), then high → qual_cnt restarts; reset_out[0] falls 18 edges after the final rise; loss_count=0.
- Lock loss in RUN: drop locked_async → reset_out=3'b111 and ready=0 two edges after the drop reaches locked_s (SYNC_STAGES+1 edges total); loss_count=1; re-raise lock → full 18/26/34 sequence repeats.
- Software reset in RUN: 1-cycle sw_reset_req → reset_out=3'b111 next edge, held 4 edges; then [0] falls, [1] 8 edges later, [2] 16 edges later; loss_count unchanged.
- Priority and saturation: sw_reset_req coincident with locked_s falling → QUALIFY taken, loss_count increments. LOSS_WIDTH=2 with 5 losses → loss_count holds 3.
- Async reset and params: assert reset mid-RELEASE between clock edges → outputs all 1s, ready=0, loss_count=0 before the next edge. Rerun power-up with NUM_OUTPUTS=1, LOCK_CYCLES=1, SYNC_STAGES=3 → reset_out[0] and ready change at edge 4.
